// File: rtl/inverse_seq_ctrl.sv
// -----------------------------------------------------------------------------
// inverse_seq_ctrl
//
// Purpose:
//   Sequencer for a 5x5 Gauss-Jordan inversion. A run has three parts:
//     1. Load. It streams the 25 coefficients from a ROM into the matrix
//        register file, in row-major order.
//     2. Row operations. For each pivot k = 0..4 it issues one NORM op on
//        row k. It then issues one ELIM op on every other row, in ascending
//        order. A shared datapath accepts these ops through a valid/ready
//        handshake.
//     3. Finish. It pulses done for one cycle.
//
// Configuration:
//   PIVOT_CHECK_EN  When this macro is defined, a zero pivot seen in CHECK
//                   aborts the run and sets singular. When it is undefined,
//                   pivot_zero is ignored and singular is always 0.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       run request, sampled only in IDLE
//   busy        run in progress (through the done cycle)
//   done        one-cycle end-of-run pulse
//   singular    last run aborted on a zero pivot
//   rom_addr    coefficient ROM address (0..24)
//   rom_data    ROM read data, one cycle after rom_addr
//   ld_we       matrix register-file write enable
//   ld_row      matrix register-file write row
//   ld_col      matrix register-file write column
//   ld_data     matrix register-file write data
//   op_valid    row operation offered to the datapath
//   op_ready    datapath accepts the row operation
//   op_code     0 = NORM, 1 = ELIM
//   op_pivot    pivot index k
//   op_row      target row i
//   pivot_zero  datapath flag: a[op_pivot][op_pivot] == 0
// -----------------------------------------------------------------------------
module inverse_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        singular,
    output logic [4:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        ld_we,
    output logic [2:0]  ld_row,
    output logic [2:0]  ld_col,
    output logic [31:0] ld_data,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  op_code,
    output logic [2:0]  op_pivot,
    output logic [2:0]  op_row,
    input  logic        pivot_zero
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_CHECK     = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_LAST = 3'd4,
        S_FIN       = 3'd5
    } state_t;

    localparam logic [1:0] OP_NORM = 2'd0;
    localparam logic [1:0] OP_ELIM = 2'd1;

    state_t      r_state;
    state_t      w_state_next;

    logic [4:0]  r_rom_addr;
    logic [2:0]  r_load_row;     // row/col that track r_rom_addr, so no divide is needed
    logic [2:0]  r_load_col;
    logic        r_ld_we;
    logic [2:0]  r_ld_row;
    logic [2:0]  r_ld_col;
    logic [2:0]  r_k;            // current pivot
    logic [2:0]  r_j;            // op slot within a pivot: 0 = NORM, 1..4 = ELIM
    logic        r_singular;

    logic        w_xfer;
    logic        w_last_op;
    logic        w_pivot_bad;
    logic [2:0]  w_elim_row;

`ifdef PIVOT_CHECK_EN
    assign w_pivot_bad = pivot_zero;
`else
    logic w_unused_pivot_zero;
    assign w_unused_pivot_zero = pivot_zero;
    assign w_pivot_bad         = 1'b0;
`endif

    assign w_xfer    = (r_state == S_ISSUE) && op_ready;
    assign w_last_op = (r_j == 3'd4);

    // ELIM slot j (1..4) maps to the j-th row in ascending order, with the
    // pivot row k skipped.
    assign w_elim_row = ((r_j - 3'd1) < r_k) ? (r_j - 3'd1) : r_j;

    // Next-state and output decode.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        op_valid     = 1'b0;
        op_code      = OP_NORM;
        op_pivot     = 3'd0;
        op_row       = 3'd0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (r_rom_addr == 5'd24) begin
                    w_state_next = S_WAIT_LAST;
                end
            end
            S_WAIT_LAST: begin
                // Wait one cycle for the write of address 24 to complete.
                busy         = 1'b1;
                w_state_next = S_CHECK;
            end
            S_CHECK: begin
                busy     = 1'b1;
                op_pivot = r_k;
                if (w_pivot_bad) begin
                    w_state_next = S_FIN;
                end else begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                op_pivot = r_k;
                if (r_j == 3'd0) begin
                    op_code = OP_NORM;
                    op_row  = r_k;
                end else begin
                    op_code = OP_ELIM;
                    op_row  = w_elim_row;
                end
                if (w_xfer && w_last_op) begin
                    w_state_next = (r_k == 3'd4) ? S_FIN : S_CHECK;
                end
            end
            S_FIN: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rom_addr <= 5'd0;
            r_load_row <= 3'd0;
            r_load_col <= 3'd0;
            r_ld_we    <= 1'b0;
            r_ld_row   <= 3'd0;
            r_ld_col   <= 3'd0;
            r_k        <= 3'd0;
            r_j        <= 3'd0;
            r_singular <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // The write stage trails the address by one cycle, which matches
            // the ROM read latency.
            r_ld_we  <= (r_state == S_LOAD);
            r_ld_row <= (r_state == S_LOAD) ? r_load_row : 3'd0;
            r_ld_col <= (r_state == S_LOAD) ? r_load_col : 3'd0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rom_addr <= 5'd0;
                        r_load_row <= 3'd0;
                        r_load_col <= 3'd0;
                        r_k        <= 3'd0;
                        r_j        <= 3'd0;
                        r_singular <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (r_rom_addr == 5'd24) begin
                        r_rom_addr <= 5'd0;
                        r_load_row <= 3'd0;
                        r_load_col <= 3'd0;
                    end else begin
                        r_rom_addr <= r_rom_addr + 5'd1;
                        if (r_load_col == 3'd4) begin
                            r_load_col <= 3'd0;
                            r_load_row <= r_load_row + 3'd1;
                        end else begin
                            r_load_col <= r_load_col + 3'd1;
                        end
                    end
                end
                S_CHECK: begin
                    r_j <= 3'd0;
                    if (w_pivot_bad) begin
                        r_singular <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_xfer) begin
                        if (w_last_op) begin
                            r_j <= 3'd0;
                            if (r_k != 3'd4) begin
                                r_k <= r_k + 3'd1;
                            end
                        end else begin
                            r_j <= r_j + 3'd1;
                        end
                    end
                end
                S_FIN: begin
                    r_k <= 3'd0;
                    r_j <= 3'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr = r_rom_addr;
    assign ld_we    = r_ld_we;
    assign ld_row   = r_ld_row;
    assign ld_col   = r_ld_col;
    assign ld_data  = r_ld_we ? rom_data : 32'd0;
    assign singular = r_singular;

endmodule

// File: tb/tb_inverse_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inverse_seq_ctrl
//
// Drives inverse_seq_ctrl with a ROM model and a randomized datapath
// handshake. It checks the load writes, the order of the row operations,
// run latency and the reset behaviour against expectations that it builds
// with plain loops.
// -----------------------------------------------------------------------------
module tb_inverse_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        singular;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
    logic        ld_we;
    logic [2:0]  ld_row;
    logic [2:0]  ld_col;
    logic [31:0] ld_data;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [2:0]  op_pivot;
    logic [2:0]  op_row;
    logic        pivot_zero;

    int          checks = 0;
    int          errors = 0;

    // Pivot-zero stimulus: 0 = never, 1 = always, 2 = whenever op_pivot == pz_k.
    int          pz_mode = 0;
    logic [2:0]  pz_k    = 3'd0;

    logic [31:0] rom [0:31];
    int          exp_code  [0:24];
    int          exp_pivot [0:24];
    int          exp_row   [0:24];

    inverse_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .singular   (singular),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ld_we      (ld_we),
        .ld_row     (ld_row),
        .ld_col     (ld_col),
        .ld_data    (ld_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_pivot   (op_pivot),
        .op_row     (op_row),
        .pivot_zero (pivot_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data is valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    assign pivot_zero = (pz_mode == 1) || ((pz_mode == 2) && (op_pivot == pz_k));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one job from IDLE. It is entered and left on a falling edge.
    // rst_op >= 0 asserts reset (with start) while that op index is pending,
    // and returns immediately.
    task automatic run_job(input int stall, input bit hold, input int rst_op,
                           input int exp_ops, input int exp_done, input logic exp_sing);
        int cyc;
        int op_idx;
        int wr_idx;
        int wait_cnt;
        int done_cyc;
        bit fin;
        for (int a = 0; a < 32; a++) rom[a] = $urandom;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        cyc = 1; op_idx = 0; wr_idx = 0; wait_cnt = 0; done_cyc = -1; fin = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("singular_cleared", {31'd0, singular}, 32'd0);
        while (!fin) begin
            if (cyc <= 25) chk("rom_addr", {27'd0, rom_addr}, cyc - 1);
            if (ld_we) begin
                if (wr_idx < 25) begin
                    chk("ld_row", {29'd0, ld_row}, wr_idx / 5);
                    chk("ld_col", {29'd0, ld_col}, wr_idx % 5);
                    chk("ld_data", ld_data, rom[wr_idx]);
                end else begin
                    chk("extra_write", wr_idx + 1, 25);
                end
                wr_idx++;
            end
            if (op_valid) begin
                if (op_idx < 25) begin
                    chk("op_code", {30'd0, op_code}, exp_code[op_idx]);
                    chk("op_pivot", {29'd0, op_pivot}, exp_pivot[op_idx]);
                    chk("op_row", {29'd0, op_row}, exp_row[op_idx]);
                end else begin
                    chk("extra_op", op_idx + 1, 25);
                end
                if (op_idx == rst_op) begin
                    op_ready = 1'b0;
                    reset    = 1'b1;
                    start    = 1'b1;
                    return;
                end
                if (wait_cnt >= stall) begin
                    op_ready = 1'b1;
                    op_idx++;
                    wait_cnt = 0;
                end else begin
                    op_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                op_ready = 1'($urandom_range(0, 1));
            end
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", {31'd0, busy}, 32'd1);
                fin = 1'b1;
            end else if (cyc >= 400) begin
                chk("timeout", cyc, exp_done);
                fin = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_cycle", done_cyc, exp_done);
        chk("op_count", op_idx, exp_ops);
        chk("write_count", wr_idx, 25);
        chk("singular_end", {31'd0, singular}, {31'd0, exp_sing});
        op_ready = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", {31'd0, done}, 32'd0);
        chk("busy_after_run", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_singular"}, {31'd0, singular}, 32'd0);
        chk({tag, "_op_valid"}, {31'd0, op_valid}, 32'd0);
        chk({tag, "_ld_we"},    {31'd0, ld_we},    32'd0);
        chk({tag, "_rom_addr"}, {27'd0, rom_addr}, 32'd0);
        chk({tag, "_ld_row"},   {29'd0, ld_row},   32'd0);
        chk({tag, "_ld_col"},   {29'd0, ld_col},   32'd0);
        chk({tag, "_ld_data"},  ld_data,           32'd0);
        chk({tag, "_op_code"},  {30'd0, op_code},  32'd0);
        chk({tag, "_op_pivot"}, {29'd0, op_pivot}, 32'd0);
        chk({tag, "_op_row"},   {29'd0, op_row},   32'd0);
    endtask

    initial begin
        int n;
        // Expected op sequence: per pivot k, NORM on row k, then ELIM on every other row in ascending order.
        n = 0;
        for (int k = 0; k < 5; k++) begin
            exp_code[n] = 0; exp_pivot[n] = k; exp_row[n] = k; n++;
            for (int i = 0; i < 5; i++) begin
                if (i != k) begin
                    exp_code[n] = 1; exp_pivot[n] = k; exp_row[n] = i; n++;
                end
            end
        end
        for (int a = 0; a < 32; a++) rom[a] = 32'd0;

        reset = 1'b1; start = 1'b0; op_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Full run, op_ready always accepts.
        run_job(0, 1'b0, -1, 25, 57, 1'b0);
        // Every op is stalled for 3 cycles.
        run_job(3, 1'b0, -1, 25, 132, 1'b0);

        // Reset (together with start) while op 8, ELIM k=1 row 3, is pending.
        run_job(0, 1'b0, 8, 25, 57, 1'b0);
        @(negedge clk);
        chk_all_zero("mid_issue_reset");
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {31'd0, busy}, 32'd0);
        run_job(0, 1'b0, -1, 25, 57, 1'b0);

        // start held high through the whole run: the next run only begins from IDLE.
        run_job(1, 1'b1, -1, 25, 82, 1'b0);
        @(negedge clk);
        chk("second_run_busy", {31'd0, busy}, 32'd1);
        chk("second_run_addr", {27'd0, rom_addr}, 32'd0);
        start = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef PIVOT_CHECK_EN
        // Zero pivot at k=2: abort after 10 ops and set singular.
        pz_mode = 2; pz_k = 3'd2;
        run_job(0, 1'b0, -1, 10, 40, 1'b1);
        pz_mode = 0;
        run_job(0, 1'b0, -1, 25, 57, 1'b0);
`else
        // pivot_zero has no effect in this build.
        pz_mode = 1;
        run_job(0, 1'b0, -1, 25, 57, 1'b0);
        pz_mode = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
